// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer sequencers (conv, pooling, dense).
// Holds the controller state encoding and the output-map size arithmetic.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

    // Output extent of a 3x3 window sliding over `img` pixels with `stride`.
    function automatic int out_dim(input int img, input int stride);
        return (img - 3) / stride + 1;
    endfunction

    function automatic int out_size(input int w, input int h, input int stride);
        return out_dim(w, stride) * out_dim(h, stride);
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order address counter; saturates at TERM and flags it.
// Used for both the input pixel address and the output result address.
module raster_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int TERM   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    assign tc = (cnt == ADDR_W'(TERM));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/conv_layer_stream_ctrl.sv
// Sequencer for one 3x3 multi-channel conv block: clears the datapath, streams
// the input map in raster order, and writes the conv results to the output buffer.
module conv_layer_stream_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32,
    parameter int Stride     = 1,
    parameter int Channels   = 6,
    parameter int ADDR_W     = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err_timeout,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [Channels*Datawidth-1:0] rd_data,
    output logic                          conv_clr,
    output logic                          conv_valid_in,
    output logic [Channels*Datawidth-1:0] conv_in,
    input  logic                          conv_valid_out,
    input  logic [Datawidth-1:0]          conv_out,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [Datawidth-1:0]          wr_data
);

    localparam int P      = IMG_Width * IMG_Height;
    localparam int N_OUT  = out_size(IMG_Width, IMG_Height, Stride);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    if (longint'(P) > (longint'(1) << ADDR_W)) begin : g_bad_size
        $error("conv_layer_stream_ctrl: input map does not fit in ADDR_W");
    end
    if (Stride != 1 && Stride != 2) begin : g_bad_stride
        $error("conv_layer_stream_ctrl: Stride must be 1 or 2");
    end

    ctrl_state_t        state, state_nx;
    logic [ADDR_W-1:0]  in_cnt, out_cnt;
    logic               in_tc, out_tc;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               accept, capture, drain_done, timeout_hit;

    assign accept     = (state == ST_IDLE) && start;
    assign capture    = (state == ST_FEED || state == ST_DRAIN) && conv_valid_out && !out_tc;
    // A write still in flight must land before the run is declared complete.
    assign drain_done = (state == ST_DRAIN) && out_tc && !wr_en;
    assign timeout_hit = (state == ST_DRAIN) && !drain_done && !conv_valid_out &&
                         (idle_cnt == IDLE_W'(TIMEOUT - 1));

    raster_addr_gen #(.ADDR_W(ADDR_W), .TERM(P - 1)) u_in_addr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == ST_FEED),
        .cnt (in_cnt),
        .tc  (in_tc)
    );

    raster_addr_gen #(.ADDR_W(ADDR_W), .TERM(N_OUT)) u_out_addr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (capture),
        .cnt (out_cnt),
        .tc  (out_tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = ST_FEED;
            ST_FEED:  if (in_tc) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_done || timeout_hit) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign busy     = (state == ST_CLEAR) || (state == ST_FEED) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign conv_clr = (state == ST_CLEAR);
    assign rd_en    = (state == ST_FEED);
    assign rd_addr  = in_cnt;
    // RAM data arrives one cycle after the read; qualify it with the delayed strobe.
    assign conv_in  = conv_valid_in ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid_in <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            idle_cnt      <= '0;
            err_timeout   <= 1'b0;
        end else begin
            conv_valid_in <= rd_en;
            wr_en         <= capture;
            if (capture) begin
                wr_addr <= out_cnt;
                wr_data <= conv_out;
            end
            if (accept || capture)
                idle_cnt <= '0;
            else if (state == ST_DRAIN && !conv_valid_out)
                idle_cnt <= idle_cnt + 1'b1;
            if (accept)
                err_timeout <= 1'b0;
            else if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_layer_stream_ctrl.sv
// Scoreboard bench: two controller instances (4x4 stride 1, 5x5 stride 2) driven by
// a behavioural RAM and conv-datapath model; writes are checked against a queue.
module tb_conv_layer_stream_ctrl;

    localparam int DW = 32;
    localparam int CH = 6;
    localparam int CW = CH * DW;
    localparam int AW = 10;
    localparam int IW_A = 4, S_A = 1, TO_A = 8;
    localparam int IW_B = 5, S_B = 2, TO_B = 64;
    localparam int P_A = IW_A * IW_A;
    localparam int P_B = IW_B * IW_B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = '0;

    wire [1:0]    busy, done, err, rd_en, conv_clr, conv_vin, wr_en;
    wire [AW-1:0] rd_addr [2];
    wire [AW-1:0] wr_addr [2];
    wire [DW-1:0] wr_data [2];
    wire [CW-1:0] conv_in [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_g   = 0;
    int skip_n [2] = '{0, 0};
    int dmax   [2] = '{3, 3};
    bit inject [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int IW   = (g == 0) ? IW_A : IW_B;
        localparam int S    = (g == 0) ? S_A  : S_B;
        localparam int TO   = (g == 0) ? TO_A : TO_B;
        localparam int P    = IW * IW;
        localparam int NOUT = ((IW - 3) / S + 1) * ((IW - 3) / S + 1);

        logic [CW-1:0] mem [P];
        logic [CW-1:0] rdat = '0;
        logic          cvo  = 1'b0;
        logic [DW-1:0] cout = '0;

        int                   due_q [$];
        logic [DW-1:0]        dat_q [$];
        logic [AW+DW-1:0]     sb_q  [$];
        int pix, made, emitted, fidx, last_due;

        initial begin
            for (int i = 0; i < P; i++)
                for (int c = 0; c < CH; c++)
                    mem[i][c*DW +: DW] = $urandom();
        end

        conv_layer_stream_ctrl #(
            .IMG_Width(IW), .IMG_Height(IW), .Datawidth(DW), .Stride(S),
            .Channels(CH), .ADDR_W(AW), .TIMEOUT(TO)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .err_timeout    (err[g]),
            .rd_en          (rd_en[g]),
            .rd_addr        (rd_addr[g]),
            .rd_data        (rdat),
            .conv_clr       (conv_clr[g]),
            .conv_valid_in  (conv_vin[g]),
            .conv_in        (conv_in[g]),
            .conv_valid_out (cvo),
            .conv_out       (cout),
            .wr_en          (wr_en[g]),
            .wr_addr        (wr_addr[g]),
            .wr_data        (wr_data[g])
        );

        always @(posedge clk)
            if (rd_en[g] && rd_addr[g] < P) rdat <= mem[rd_addr[g]];

        // Conv datapath model: a result per completed window, emitted after a random delay.
        always @(negedge clk) begin : model
            int r, c, d;
            logic [DW-1:0] res;
            if (rst || conv_clr[g]) begin
                due_q.delete(); dat_q.delete(); sb_q.delete();
                pix = 0; made = 0; emitted = 0; fidx = 0; last_due = 0;
                cvo = 1'b0; cout = '0;
            end else begin
                if (rd_en[g]) begin
                    chk("rd_addr", rd_addr[g], fidx);
                    fidx++;
                end
                if (conv_vin[g]) begin
                    chk_w("conv_in", conv_in[g], (pix < P) ? mem[pix] : '0);
                    r = pix / IW;
                    c = pix % IW;
                    if (r >= 2 && c >= 2 && (r - 2) % S == 0 && (c - 2) % S == 0) begin
                        if (made >= skip_n[g]) begin
                            d = cyc_g + $urandom_range(1, dmax[g]);
                            if (d <= last_due) d = last_due + 1;
                            res = $urandom();
                            due_q.push_back(d); dat_q.push_back(res); last_due = d;
                        end
                        made++;
                        if (made == NOUT && inject[g]) begin
                            res = $urandom();
                            due_q.push_back(last_due + 1); dat_q.push_back(res);
                            last_due = last_due + 1;
                        end
                    end
                    pix++;
                end
                cvo = 1'b0;
                if (due_q.size() > 0 && due_q[0] <= cyc_g) begin
                    cvo  = 1'b1;
                    cout = dat_q[0];
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                    if (emitted < NOUT) sb_q.push_back({AW'(emitted), cout});
                    emitted++;
                end
            end
        end

        always @(negedge clk) begin : wr_mon
            logic [AW+DW-1:0] e;
            if (!rst && wr_en[g]) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected[%0d]: got write addr %0h data %0h, expected none",
                             g, wr_addr[g], wr_data[g]);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", wr_addr[g], e[DW +: AW]);
                    chk("wr_data", wr_data[g], e[DW-1:0]);
                end
            end
        end
    end

    task automatic chk_reset(input int g);
        chk("rst_busy", busy[g], 0);
        chk("rst_done", done[g], 0);
        chk("rst_err", err[g], 0);
        chk("rst_rd_en", rd_en[g], 0);
        chk("rst_rd_addr", rd_addr[g], 0);
        chk("rst_conv_clr", conv_clr[g], 0);
        chk("rst_conv_vin", conv_vin[g], 0);
        chk_w("rst_conv_in", conv_in[g], '0);
        chk("rst_wr_en", wr_en[g], 0);
        chk("rst_wr_addr", wr_addr[g], 0);
        chk("rst_wr_data", wr_data[g], 0);
    endtask

    task automatic idle_check(input int g, input int n, input bit exp_err);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", busy[g], 0);
            chk("idle_done", done[g], 0);
            chk("idle_clr", conv_clr[g], 0);
            chk("idle_err", err[g], exp_err);
        end
    endtask

    // Issues start right after a negedge and follows the run to its done cycle.
    task automatic run(input int g, input int exp_wr, input bit exp_err, input bit hold);
        int cyc, n_clr, n_rd, n_vin, n_wr, first_rd, first_vin, last_wr, p, to;
        bit got;
        p = (g == 0) ? P_A : P_B;
        to = (g == 0) ? TO_A : TO_B;
        cyc = 0; n_clr = 0; n_rd = 0; n_vin = 0; n_wr = 0;
        first_rd = -1; first_vin = -1; last_wr = -1; got = 1'b0;
        start[g] = 1'b1;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) start[g] = 1'b0;
            if (cyc == 1) begin
                chk("clr_at_1", conv_clr[g], 1);
                chk("busy_at_1", busy[g], 1);
                chk("err_at_1", err[g], 0);
            end
            if (conv_clr[g]) n_clr++;
            if (rd_en[g]) begin n_rd++; if (first_rd < 0) first_rd = cyc; end
            if (conv_vin[g]) begin n_vin++; if (first_vin < 0) first_vin = cyc; end
            if (wr_en[g]) begin n_wr++; last_wr = cyc; end
            if (done[g]) got = 1'b1;
        end
        start[g] = 1'b0;
        chk("done_seen", got, 1);
        chk("clr_count", n_clr, 1);
        chk("rd_count", n_rd, p);
        chk("vin_count", n_vin, p);
        chk("first_rd_cycle", first_rd, 2);
        chk("first_vin_cycle", first_vin, 3);
        chk("wr_count", n_wr, exp_wr);
        chk("busy_at_done", busy[g], 0);
        chk("err_at_done", err[g], exp_err);
        if (exp_err) chk("timeout_gap", cyc - last_wr, to);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(negedge clk);

        repeat (3) begin
            run(0, 4, 1'b0, 1'b0);
            idle_check(0, 2, 1'b0);
        end

        skip_n[0] = 2;
        run(0, 2, 1'b1, 1'b0);
        idle_check(0, 3, 1'b1);
        skip_n[0] = 0;
        run(0, 4, 1'b0, 1'b0);
        idle_check(0, 2, 1'b0);

        run(0, 4, 1'b0, 1'b1);
        idle_check(0, 4, 1'b0);

        // start present only across the DONE cycle must not launch a run
        run(0, 4, 1'b0, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        idle_check(0, 3, 1'b0);

        dmax[0] = 1;
        run(0, 4, 1'b0, 1'b0);
        @(negedge clk);
        run(0, 4, 1'b0, 1'b0);
        idle_check(0, 2, 1'b0);
        dmax[0] = 3;

        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 0;
        while (!(rd_en[0] && rd_addr[0] == 7) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("reached_addr7", rd_addr[0], 7);
        rst = 1'b1;
        @(negedge clk);
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0;
        idle_check(0, 3, 1'b0);
        run(0, 4, 1'b0, 1'b0);
        idle_check(0, 2, 1'b0);

        inject[1] = 1'b1;
        run(1, 4, 1'b0, 1'b0);
        idle_check(1, 3, 1'b0);
        inject[1] = 1'b0;
        run(1, 4, 1'b0, 1'b0);
        idle_check(1, 3, 1'b0);

        chk("sb_empty0", g_dut[0].sb_q.size(), 0);
        chk("sb_empty1", g_dut[1].sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_layer_stream_ctrl.md
Name: conv_layer_stream_ctrl

Overview:
Sequencer for one multi-channel 3x3 convolution layer block (6 input channels summed into one output channel plus bias). On `start` it clears the conv line buffers and streams one full input feature map in raster order from a packed feature-map RAM. It collects the conv results and writes them to an output buffer, then reports done. It sits between the layer's input/output buffers and the conv datapath, one instance per conv block in the tiny-model pipeline.

Parameters:
IMG_Width, 3, input map width in pixels (>=3)
IMG_Height, 3, input map height in pixels (>=3)
Datawidth, 32, bits per channel sample and per result
Stride, 1, conv stride (1 or 2)
Channels, 6, input channels packed per RAM word
ADDR_W, 10, address width of input RAM and output buffer
TIMEOUT, 64, max DRAIN cycles without a new result before the run aborts

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  run request; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
err_timeout  out  1  sticky; set when DRAIN times out, cleared by next accepted start
rd_en  out  1  input RAM read strobe
rd_addr  out  ADDR_W  input pixel address, raster order
rd_data  in  Channels*Datawidth  RAM word, channel 0 in LSBs, 1-cycle read latency
conv_clr  out  1  clear pulse to conv datapath
conv_valid_in  out  1  pixel valid to conv datapath
conv_in  out  Channels*Datawidth  pixel bus to conv datapath (In_0 = LSBs)
conv_valid_out  in  1  result valid from conv datapath
conv_out  in  Datawidth  result from conv datapath
wr_en  out  1  output buffer write strobe
wr_addr  out  ADDR_W  output address, raster order of result map
wr_data  out  Datawidth  result to write

Behaviour:
- Clock `clk`. Reset `rst` is synchronous and active-high.
- Derived constants:
  - P = IMG_Width*IMG_Height
  - OUT_W = (IMG_Width-3)/Stride+1
  - OUT_H = (IMG_Height-3)/Stride+1
  - N_OUT = OUT_W*OUT_H
- Reset: state=IDLE, all counters 0. busy, done, err_timeout, rd_en, conv_clr, conv_valid_in and wr_en are 0. rd_addr, wr_addr, wr_data and conv_in are 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 in cycle T moves to CLEAR at T+1.
  - On that transition: clear err_timeout, in_cnt, out_cnt and idle_cnt.
- CLEAR (exactly 1 cycle): conv_clr=1 and busy=1. Next state is FEED.
- FEED (exactly P cycles): rd_en=1, rd_addr=in_cnt, in_cnt increments every cycle. After address P-1, next state is DRAIN.
- Pixel forwarding:
  - conv_valid_in is rd_en delayed 1 cycle.
  - conv_in is rd_data, passed combinationally and aligned with the delayed valid.
  - The last pixel therefore enters the datapath on the first DRAIN cycle.
- Result capture (in FEED and DRAIN only):
  - When conv_valid_out=1 and out_cnt<N_OUT: next cycle wr_en=1, wr_data=conv_out, wr_addr=out_cnt; out_cnt increments.
  - Results arriving with out_cnt==N_OUT, or in IDLE, CLEAR or DONE, are dropped with no write.
- DRAIN:
  - idle_cnt increments each cycle without conv_valid_out and resets to 0 on a captured result.
  - When out_cnt==N_OUT and no write is pending, go to DONE.
  - If idle_cnt reaches TIMEOUT, set err_timeout=1 and go to DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
- busy is 1 in CLEAR, FEED and DRAIN.
- start while busy is ignored and not queued. start in the DONE cycle is ignored.
- rst asserted mid-run aborts immediately to reset values in the next cycle. No done pulse is issued.
- Arithmetic: counters are ADDR_W wide. No result arithmetic in this block; data passes through bit-exact.
- Elaboration errors:
  - P > 2**ADDR_W is illegal and flagged.
  - Stride other than 1 or 2 is illegal and flagged.

Decomposition:
- Shared package `cnn_ctrl_pkg`:
  - FSM state enum
  - a derived-size function for OUT_W/OUT_H/N_OUT, reused by pooling and dense controllers
- Sub-module `raster_addr_gen`: counter with enable, clear and terminal-count flag. Instantiate it twice, for the input address and the output address.
- The conv datapath itself is not instantiated here; the top layer wires it.

Test Plan:
- Basic run, W=H=4, Stride=1: pulse start at cycle 0.
  - conv_clr at cycle 1; rd_addr 0..15 over cycles 2..17; conv_valid_in over cycles 3..18.
  - Bench conv model returns 4 results; expect wr_addr 0,1,2,3 with matching data, then a single done pulse, err_timeout=0.
- Stride=2, W=H=5: expect N_OUT=4 writes. A fifth injected conv_valid_out is dropped with no wr_en.
- Timeout, TIMEOUT=8: the model returns only 2 of 4 results.
  - done occurs 8 cycles after the last result, err_timeout=1.
  - The next start clears err_timeout.
- start held high during busy: exactly one run, one done. A new run starts only on start sampled in IDLE after done.
- rst asserted mid-FEED at rd_addr=7: next cycle all outputs are at reset values, no done. A fresh start then replays from rd_addr=0 with conv_clr.
- Back-to-back: start pulsed in the cycle after done. The second run completes identically, with wr_addr restarting at 0.
